tdm_demultiplexer: RTL and testbench
====================================

# tdm_demultiplexer

Time-division demultiplexer: receives a stream of WIDTH-bit words in which CHANNELS channels take turns, marked by a slot-0 frame marker. Each word is routed to its channel's registered output. This is the receive end of the team's channel-select multiplexers. A small lock state machine, a slot counter and frame-error detection make the block tolerant of gaps and misaligned frames.

## Interface
- WIDTH, 8, bits per channel word
- CHANNELS, 4, channels per frame (≥1); slot counter width = max(1, $clog2(CHANNELS))
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data carries a word this cycle
- in_data  input  WIDTH  multiplexed word
- frame_start  input  1  word on in_data is slot 0; ignored when in_valid=0
- out_data  output  CHANNELS*WIDTH  channel c at bits [c*WIDTH +: WIDTH], registered
- out_valid  output  CHANNELS  one-cycle strobe per channel on update
- frame_done  output  1  one-cycle pulse when a complete frame (slots 0..CHANNELS-1) received
- sync_err  output  1  one-cycle pulse on framing violation
- locked  output  1  high in LOCKED state

## Operation
- States: HUNT (reset state), LOCKED. locked = (state == LOCKED).
- Accepted word = in_valid=1 and the word is not dropped. in_valid=0 cycles are gaps: no state or counter change.
- HUNT:
  - in_valid & frame_start: accept as slot 0, go LOCKED, slot ← 1.
  - in_valid & !frame_start: drop word, no error.
- LOCKED, in_valid, expected slot s:
  - s=0 & frame_start: accept as slot 0.
  - s=0 & !frame_start: drop word, pulse sync_err, go HUNT.
  - s≠0 & !frame_start: accept as slot s.
  - s≠0 & frame_start: pulse sync_err, discard partial frame (no frame_done), accept word as slot 0, slot ← 1, stay LOCKED.
  - After slot CHANNELS-1 is accepted: slot wraps to 0 and frame_done pulses.
- CHANNELS=1: every word must carry frame_start; each accepted word also produces frame_done.
- out_data channels not written keep their previous value.

## Timing
- Reset values: out_data=0, out_valid=0, frame_done=0, sync_err=0, locked=0; state HUNT; slot 0; shadow registers 0.
- rst has priority over all inputs. A reset mid-frame discards the partial frame with no frame_done and no sync_err.
- Latency: a word accepted at edge k appears on out_data and raises out_valid[slot] in the cycle after edge k. The strobe lasts exactly one cycle.
- frame_done is asserted in the same cycle as out_valid for the last slot.
- sync_err is asserted in the cycle after the offending word's edge.
- locked rises the cycle after the first accepted frame_start. It falls the cycle after a dropped slot-0 word.
- Back-to-back words, one per cycle, are supported with no bubbles.

## Configuration
- Macro: TDM_DEMUX_FRAME_HOLD_EN.
- Undefined:
  - Each channel's out_data updates as its slot arrives, per the rules above.
  - Partial frames are visible on out_data.
- Defined:
  - Accepted words go to CHANNELS×WIDTH shadow registers.
  - On completion of the last slot, all out_data channels update together, all out_valid bits pulse together, and frame_done pulses, all in the cycle after the last word's edge.
  - A discarded partial frame (sync_err or reset) never reaches out_data.

## Test plan
- Reset, then send frame_start+0x11, 0x22, 0x33, 0x44, one per cycle.
  - Without HOLD: out_valid = 0001, 0010, 0100, 1000 on consecutive cycles; out_data=0x44332211; frame_done pulses with 1000.
  - With HOLD: out_valid=1111 once, with frame_done.
- Send 0xAA, 0xBB without frame_start after reset -> words dropped; out_data stays 0; locked=0; sync_err=0.
- Locked; send frame_start+0x01, 0x02, then frame_start+0x10, 0x20, 0x30, 0x40.
  - sync_err pulses once; frame_done pulses only after 0x40; final out_data=0x40302010.
  - With HOLD, 0x02 never appears on out_data.
- Locked; full frame, then a slot-0 word 0x55 without frame_start -> sync_err pulses; locked falls; 0x55 not written; subsequent words ignored until frame_start.
- Frame with in_valid low for 3 cycles between slots 1 and 2 -> outputs identical to the gapless case, delayed by 3 cycles; no sync_err.
- Assert rst after slot 2 of a frame -> all outputs 0 the next cycle; state HUNT; no frame_done; a following full frame decodes correctly.

Source files
------------

// File: rtl/tdm_demultiplexer_if.sv
// Handshake/bus bundle for the TDM demultiplexer.
// Master drives the multiplexed stream; slave is the demux.
interface tdm_demultiplexer_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    logic                      in_valid;
    logic [WIDTH-1:0]          in_data;
    logic                      frame_start;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic [CHANNELS-1:0]       out_valid;
    logic                      frame_done;
    logic                      sync_err;
    logic                      locked;

    modport master (
        output in_valid,
        output in_data,
        output frame_start,
        input  out_data,
        input  out_valid,
        input  frame_done,
        input  sync_err,
        input  locked
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  frame_start,
        output out_data,
        output out_valid,
        output frame_done,
        output sync_err,
        output locked
    );
endinterface

// File: rtl/tdm_demultiplexer.sv
// TDM demultiplexer with HUNT/LOCKED framing and slot counter.
// Define TDM_DEMUX_FRAME_HOLD_EN to publish only complete frames.
module tdm_demultiplexer #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                clk,
    input  logic                rst,
    tdm_demultiplexer_if.slave  bus
);
    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [SW-1:0] LAST = SW'(CHANNELS - 1);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    state_t                    state_q, state_d;
    logic [SW-1:0]             slot_q, slot_d;
    logic                      accept;
    logic                      err;
    logic                      last;
    logic [SW-1:0]             acc_slot;

    logic [CHANNELS*WIDTH-1:0] out_data_q, out_data_d;
    logic [CHANNELS-1:0]       out_valid_q, out_valid_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
`ifdef TDM_DEMUX_FRAME_HOLD_EN
    logic [CHANNELS*WIDTH-1:0] shadow_q, shadow_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        accept   = 1'b0;
        err      = 1'b0;
        acc_slot = slot_q;
        if (bus.in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.frame_start) begin
                        accept   = 1'b1;
                        acc_slot = '0;
                        state_d  = LOCKED;
                    end
                end
                LOCKED: begin
                    if (slot_q == '0) begin
                        if (bus.frame_start) begin
                            accept   = 1'b1;
                            acc_slot = '0;
                        end else begin
                            err     = 1'b1;
                            state_d = HUNT;
                        end
                    end else if (bus.frame_start) begin
                        // Realign on the new marker, dropping the partial frame
                        err      = 1'b1;
                        accept   = 1'b1;
                        acc_slot = '0;
                    end else begin
                        accept = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        last = accept && (acc_slot == LAST);
        if (accept) begin
            slot_d = last ? '0 : acc_slot + 1'b1;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = '0;
        done_d      = last;
        err_d       = err;
        bus.locked  = (state_q == LOCKED);
`ifdef TDM_DEMUX_FRAME_HOLD_EN
        shadow_d = shadow_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (accept && acc_slot == SW'(c)) begin
                shadow_d[c*WIDTH +: WIDTH] = bus.in_data;
            end
        end
        if (last) begin
            out_data_d  = shadow_d;
            out_valid_d = '1;
        end
`else
        for (int c = 0; c < CHANNELS; c++) begin
            if (accept && acc_slot == SW'(c)) begin
                out_data_d[c*WIDTH +: WIDTH] = bus.in_data;
                out_valid_d[c]               = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef TDM_DEMUX_FRAME_HOLD_EN
            shadow_q    <= '0;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef TDM_DEMUX_FRAME_HOLD_EN
            shadow_q    <= shadow_d;
`endif
        end
    end

    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = done_q;
    assign bus.sync_err   = err_q;
endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Directed bench for tdm_demultiplexer (WIDTH=8, CHANNELS=4).
// Expectations follow TDM_DEMUX_FRAME_HOLD_EN when defined.
module tb_tdm_demultiplexer;
`ifdef TDM_DEMUX_FRAME_HOLD_EN
    localparam bit H = 1'b1;
`else
    localparam bit H = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    tdm_demultiplexer_if #(.WIDTH(8), .CHANNELS(4)) bus ();

    tdm_demultiplexer #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step(
        input string       tag,
        input logic        r,
        input logic        v,
        input logic        fs,
        input logic [7:0]  d,
        input logic [3:0]  ev,
        input logic [31:0] ed,
        input logic        edone,
        input logic        eerr,
        input logic        elk
    );
        rst             = r;
        bus.in_valid    = v;
        bus.frame_start = fs;
        bus.in_data     = d;
        @(posedge clk);
        #1;
        tests++;
        assert (bus.out_valid === ev) else begin
            fails++;
            $error("FAIL %s out_valid: got %h want %h", tag, bus.out_valid, ev);
        end
        tests++;
        assert (bus.out_data === ed) else begin
            fails++;
            $error("FAIL %s out_data: got %h want %h", tag, bus.out_data, ed);
        end
        tests++;
        assert (bus.frame_done === edone) else begin
            fails++;
            $error("FAIL %s frame_done: got %b want %b", tag, bus.frame_done, edone);
        end
        tests++;
        assert (bus.sync_err === eerr) else begin
            fails++;
            $error("FAIL %s sync_err: got %b want %b", tag, bus.sync_err, eerr);
        end
        tests++;
        assert (bus.locked === elk) else begin
            fails++;
            $error("FAIL %s locked: got %b want %b", tag, bus.locked, elk);
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.frame_start = 1'b0;
        bus.in_data     = '0;

        step("reset", 1, 0, 0, 8'h00, 4'h0, 32'h0, 0, 0, 0);

        // Basic frame
        step("f1_s0", 0, 1, 1, 8'h11, H ? 4'h0 : 4'h1,
             H ? 32'h0 : 32'h00000011, 0, 0, 1);
        step("f1_s1", 0, 1, 0, 8'h22, H ? 4'h0 : 4'h2,
             H ? 32'h0 : 32'h00002211, 0, 0, 1);
        step("f1_s2", 0, 1, 0, 8'h33, H ? 4'h0 : 4'h4,
             H ? 32'h0 : 32'h00332211, 0, 0, 1);
        step("f1_s3", 0, 1, 0, 8'h44, H ? 4'hF : 4'h8,
             32'h44332211, 1, 0, 1);
        step("f1_idle", 0, 0, 0, 8'h00, 4'h0, 32'h44332211, 0, 0, 1);

        // Words without marker in HUNT are dropped silently
        step("rst2", 1, 0, 0, 8'h00, 4'h0, 32'h0, 0, 0, 0);
        step("hunt_aa", 0, 1, 0, 8'hAA, 4'h0, 32'h0, 0, 0, 0);
        step("hunt_bb", 0, 1, 0, 8'hBB, 4'h0, 32'h0, 0, 0, 0);

        // Misaligned marker mid-frame
        step("mis_01", 0, 1, 1, 8'h01, H ? 4'h0 : 4'h1,
             H ? 32'h0 : 32'h00000001, 0, 0, 1);
        step("mis_02", 0, 1, 0, 8'h02, H ? 4'h0 : 4'h2,
             H ? 32'h0 : 32'h00000201, 0, 0, 1);
        step("mis_10", 0, 1, 1, 8'h10, H ? 4'h0 : 4'h1,
             H ? 32'h0 : 32'h00000210, 0, 1, 1);
        step("mis_20", 0, 1, 0, 8'h20, H ? 4'h0 : 4'h2,
             H ? 32'h0 : 32'h00002010, 0, 0, 1);
        step("mis_30", 0, 1, 0, 8'h30, H ? 4'h0 : 4'h4,
             H ? 32'h0 : 32'h00302010, 0, 0, 1);
        step("mis_40", 0, 1, 0, 8'h40, H ? 4'hF : 4'h8,
             32'h40302010, 1, 0, 1);

        // Missing marker at slot 0 loses lock
        step("lost_55", 0, 1, 0, 8'h55, 4'h0, 32'h40302010, 0, 1, 0);
        step("lost_66", 0, 1, 0, 8'h66, 4'h0, 32'h40302010, 0, 0, 0);

        // Gap of three idle cycles between slots 1 and 2
        step("gap_a1", 0, 1, 1, 8'hA1, H ? 4'h0 : 4'h1,
             H ? 32'h40302010 : 32'h403020A1, 0, 0, 1);
        step("gap_a2", 0, 1, 0, 8'hA2, H ? 4'h0 : 4'h2,
             H ? 32'h40302010 : 32'h4030A2A1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step("gap_idle", 0, 0, 0, 8'hEE, 4'h0,
                 H ? 32'h40302010 : 32'h4030A2A1, 0, 0, 1);
        end
        step("gap_a3", 0, 1, 0, 8'hA3, H ? 4'h0 : 4'h4,
             H ? 32'h40302010 : 32'h40A3A2A1, 0, 0, 1);
        step("gap_a4", 0, 1, 0, 8'hA4, H ? 4'hF : 4'h8,
             32'hA4A3A2A1, 1, 0, 1);

        // Reset after slot 2 discards the partial frame
        step("rs_b1", 0, 1, 1, 8'hB1, H ? 4'h0 : 4'h1,
             H ? 32'hA4A3A2A1 : 32'hA4A3A2B1, 0, 0, 1);
        step("rs_b2", 0, 1, 0, 8'hB2, H ? 4'h0 : 4'h2,
             H ? 32'hA4A3A2A1 : 32'hA4A3B2B1, 0, 0, 1);
        step("rs_b3", 0, 1, 0, 8'hB3, H ? 4'h0 : 4'h4,
             H ? 32'hA4A3A2A1 : 32'hA4B3B2B1, 0, 0, 1);
        step("rs_mid", 1, 1, 0, 8'hB4, 4'h0, 32'h0, 0, 0, 0);
        step("rs_c1", 0, 1, 1, 8'hC1, H ? 4'h0 : 4'h1,
             H ? 32'h0 : 32'h000000C1, 0, 0, 1);
        step("rs_c2", 0, 1, 0, 8'hC2, H ? 4'h0 : 4'h2,
             H ? 32'h0 : 32'h0000C2C1, 0, 0, 1);
        step("rs_c3", 0, 1, 0, 8'hC3, H ? 4'h0 : 4'h4,
             H ? 32'h0 : 32'h00C3C2C1, 0, 0, 1);
        step("rs_c4", 0, 1, 0, 8'hC4, H ? 4'hF : 4'h8,
             32'hC4C3C2C1, 1, 0, 1);
        step("rs_idle", 0, 0, 0, 8'h00, 4'h0, 32'hC4C3C2C1, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
